tone_synthesizer: RTL and testbench

Generates a square-wave audio stream for the codec's playback FIFO. It is the transmit-side counterpart of the signal analyser, which classifies incoming `left` samples into a 2-bit pitch class and a 1-bit loudness flag. This block takes the same pitch class and `volumn` flag and produces signed 24-bit samples on `left`/`right`. Samples are handed to the audio core with a `write`/`write_ready` handshake, so the codec FIFO paces the sample rate.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/square_osc.sv | 80 ++++++++
 rtl/tone_synthesizer.sv | 83 ++++++++
 tb/tb_tone_synthesizer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions for the tone synthesizer and the signal analyser.
// Contents:
//   PITCH_*   2-bit pitch class encoding, common to both directions
//   SAMPLE_W  codec sample width
//   state_e   transmit-side handshake FSM states
package audio_pkg;

  localparam logic [1:0] PITCH_LOW    = 2'b00;
  localparam logic [1:0] PITCH_MID    = 2'b01;
  localparam logic [1:0] PITCH_HIGH   = 2'b11;
  localparam logic [1:0] PITCH_SILENT = 2'b10;

  localparam int SAMPLE_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GEN   = 2'b01,
    ST_OFFER = 2'b10
  } state_e;

endpackage

// File: rtl/square_osc.sv
// Square-wave oscillator core.
// Holds the sample counter (phase), the half-wave sign (polarity) and the
// pitch class latched at the last half-period boundary.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   step_i     one-cycle strobe, advances the oscillator by one sample
//   pitch_i    requested pitch class, taken only at a half-period boundary
//   mag_i      magnitude of the current sample
//   sample_o   signed sample for the current oscillator state
module square_osc
  import audio_pkg::*;
#(
  parameter int unsigned HALF_LOW  = 120,
  parameter int unsigned HALF_MID  = 60,
  parameter int unsigned HALF_HIGH = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_i,
  input  logic [1:0]          pitch_i,
  input  logic [SAMPLE_W-1:0] mag_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  logic [7:0] phase_q, phase_d;
  logic       polarity_q, polarity_d;
  logic [1:0] cur_pitch_q, cur_pitch_d;
  logic [7:0] half_sel;

  always_comb begin
    case (cur_pitch_q)
      PITCH_LOW:  half_sel = 8'(HALF_LOW);
      PITCH_MID:  half_sel = 8'(HALF_MID);
      PITCH_HIGH: half_sel = 8'(HALF_HIGH);
      default:    half_sel = 8'd1;
    endcase
  end

  always_comb begin
    phase_d     = phase_q;
    polarity_d  = polarity_q;
    cur_pitch_d = cur_pitch_q;
    if (step_i) begin
      if (cur_pitch_q == PITCH_SILENT) begin
        // Silence parks the oscillator so the next tone starts positive.
        phase_d     = 8'd0;
        polarity_d  = 1'b0;
        cur_pitch_d = pitch_i;
      end else if (phase_q == half_sel - 8'd1) begin
        phase_d     = 8'd0;
        polarity_d  = (pitch_i == PITCH_SILENT) ? 1'b0 : ~polarity_q;
        cur_pitch_d = pitch_i;
      end else begin
        phase_d = phase_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= 8'd0;
      polarity_q  <= 1'b0;
      cur_pitch_q <= PITCH_SILENT;
    end else begin
      phase_q     <= phase_d;
      polarity_q  <= polarity_d;
      cur_pitch_q <= cur_pitch_d;
    end
  end

  always_comb begin
    if (cur_pitch_q == PITCH_SILENT)
      sample_o = '0;
    else if (polarity_q)
      sample_o = ~mag_i + {{(SAMPLE_W-1){1'b0}}, 1'b1};
    else
      sample_o = mag_i;
  end

endmodule

// File: rtl/tone_synthesizer.sv
// Square-wave tone generator feeding the codec playback FIFO.
// A GEN cycle loads the next oscillator sample into the output register, an
// OFFER phase holds it with write=1 until the FIFO takes it.
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   enable        stream samples while high
//   pitch         00 low, 01 mid, 11 high, 10 silence
//   volumn        1 selects AMP_HI, 0 selects AMP_LO (sampled in GEN)
//   write_ready   FIFO can accept a sample
//   write         left/right hold a valid sample
//   left, right   identical two's-complement samples
module tone_synthesizer
  import audio_pkg::*;
#(
  parameter int unsigned          HALF_LOW  = 120,
  parameter int unsigned          HALF_MID  = 60,
  parameter int unsigned          HALF_HIGH = 30,
  parameter logic [SAMPLE_W-1:0]  AMP_HI    = 24'h3FFFFF,
  parameter logic [SAMPLE_W-1:0]  AMP_LO    = 24'h0FFFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          pitch,
  input  logic                volumn,
  input  logic                write_ready,
  output logic                write,
  output logic [SAMPLE_W-1:0] left,
  output logic [SAMPLE_W-1:0] right
);

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [SAMPLE_W-1:0] mag;
  logic [SAMPLE_W-1:0] osc_sample;
  logic                accept;

  assign accept = (state_q == ST_OFFER) && write_ready;
  assign mag    = volumn ? AMP_HI : AMP_LO;

  square_osc #(
    .HALF_LOW  (HALF_LOW),
    .HALF_MID  (HALF_MID),
    .HALF_HIGH (HALF_HIGH)
  ) u_osc (
    .clk      (clk),
    .rst      (reset),
    .step_i   (accept),
    .pitch_i  (pitch),
    .mag_i    (mag),
    .sample_o (osc_sample)
  );

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_GEN;
      ST_GEN: begin
        left_d  = osc_sample;
        state_d = ST_OFFER;
      end
      ST_OFFER: if (write_ready) state_d = enable ? ST_GEN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
    end
  end

  // Decoded from the state register so reset drops write asynchronously.
  assign write = (state_q == ST_OFFER);
  assign left  = left_q;
  assign right = left_q;

endmodule

// File: tb/tb_tone_synthesizer.sv
module tb_tone_synthesizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pitch = 2'b00;
  logic        volumn = 1'b0;
  logic        write_ready = 1'b0;
  logic        write;
  logic [23:0] left, right;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference oscillator: sample index within the half-wave, sign, tone.
  int   m_idx;
  bit   m_neg;
  int   m_tone;          // 0 low, 1 mid, 2 silence, 3 high (pitch code)
  int   half_len [4] = '{120, 60, 0, 30};

  tone_synthesizer dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pitch       (pitch),
    .volumn      (volumn),
    .write_ready (write_ready),
    .write       (write),
    .left        (left),
    .right       (right)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_neg  = 0;
    m_tone = 2;
  endtask

  function automatic logic [31:0] model_sample();
    int a;
    if (m_tone == 2) return 32'd0;
    a = volumn ? 32'h3FFFFF : 32'h0FFFFF;
    if (m_neg) return 32'((-a) & 32'hFFFFFF);
    return 32'(a);
  endfunction

  // One transferred sample: count along the half-wave, flip and re-read
  // the requested tone when the half-wave is complete.
  task automatic model_step(input int req);
    if (m_tone == 2) begin
      m_tone = req;
      m_idx  = 0;
      m_neg  = 0;
    end else begin
      m_idx++;
      if (m_idx >= half_len[m_tone]) begin
        m_idx  = 0;
        m_neg  = !m_neg;
        m_tone = req;
      end
    end
  endtask

  // Handles n samples. Optional pitch change offered with sample chg_idx,
  // optional random stalls, random pitch and random volume.
  task automatic run_samples(input int n, input int stall_max, input int chg_idx,
                             input logic [1:0] chg_p, input bit rnd);
    for (int k = 0; k < n; k++) begin
      int cyc = 0;
      int stall;
      logic [31:0] exp;
      while (write !== 1'b1 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      if (write !== 1'b1) begin
        chk("write_timeout", 32'(write), 32'd1);
        return;
      end
      if (stall_max == 0 && k > 0) chk("gap_cycles", 32'(cyc), 32'd1);
      exp = model_sample();
      chk("left", 32'(left), exp);
      chk("right", 32'(right), exp);
      if (k == chg_idx) pitch = chg_p;
      if (rnd && $urandom_range(3) == 0) pitch = 2'($urandom_range(3));
      stall = (stall_max > 0) ? int'($urandom_range(stall_max)) : 0;
      if (stall > 0) begin
        write_ready = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          chk("stall_write", 32'(write), 32'd1);
          chk("stall_left", 32'(left), exp);
        end
      end
      write_ready = 1'b1;
      @(posedge clk);
      model_step(int'(pitch));
      @(negedge clk);
      chk("gen_write_low", 32'(write), 32'd0);
      if (stall_max > 0) write_ready = 1'($urandom);
      if (rnd) volumn = 1'($urandom);
    end
  endtask

  initial begin
    logic [31:0] held;
    int cyc;
    model_reset();

    // Reset with enable/write_ready already high, low tone requested.
    enable = 1'b1; write_ready = 1'b1; pitch = 2'b00; volumn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_left", 32'(left), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("lat1_write", 32'(write), 32'd0);
    @(negedge clk);
    chk("lat2_write", 32'(write), 32'd1);
    run_samples(3, 0, -1, 2'b00, 1'b0);
    run_samples(130, 0, -1, 2'b00, 1'b0);

    // High tone, full volume, back-to-back.
    pitch = 2'b11;
    run_samples(150, 0, -1, 2'b00, 1'b0);

    // Mid tone, low volume, switch to low tone early in a half-wave.
    pitch = 2'b01; volumn = 1'b0;
    run_samples(80, 0, -1, 2'b00, 1'b0);
    run_samples(200, 0, 10, 2'b00, 1'b0);

    // Long stall with enable dropped during it.
    cyc = 0;
    write_ready = 1'b0;
    while (write !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    chk("stall_offer", 32'(write), 32'd1);
    held = model_sample();
    chk("stall_sample", 32'(left), held);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 20) enable = 1'b0;
      chk("long_stall_write", 32'(write), 32'd1);
      chk("long_stall_left", 32'(left), held);
    end
    write_ready = 1'b1;
    @(posedge clk);
    model_step(int'(pitch));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_write", 32'(write), 32'd0);
      chk("idle_left", 32'(left), held);
    end
    enable = 1'b1;
    run_samples(40, 0, -1, 2'b00, 1'b0);

    // Asynchronous reset while a sample is offered.
    write_ready = 1'b0;
    cyc = 0;
    while (write !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    chk("pre_reset_write", 32'(write), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_write", 32'(write), 32'd0);
    chk("async_rst_left", 32'(left), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    pitch = 2'b11; volumn = 1'b1;
    run_samples(65, 0, -1, 2'b00, 1'b0);

    // Silence requested mid-waveform, then high tone again.
    run_samples(40, 0, 5, 2'b10, 1'b0);
    run_samples(5, 0, 3, 2'b11, 1'b0);
    run_samples(40, 0, -1, 2'b00, 1'b0);

    // Random stalls, pitches and volumes.
    run_samples(300, 3, -1, 2'b00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
